timer_scheduler: RTL

- Shares one programmable down-counter among N_REQ requesters. Each requester asks for a one-shot timeout of a given period.
- Round-robin arbitration picks one requester. The block loads that requester's period, counts it down and pulses that requester's expire line.
- Sits between the core's interrupt and peripheral logic and the single hardware timer resource; only one timeout is in flight at a time.

---
 rtl/timer_pkg.sv | 13 +
 rtl/timer_scheduler_rr_arbiter.sv | 38 +++
 rtl/timer_scheduler.sv | 108 ++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// Shared types and defaults for the timer scheduler.
package timer_pkg;

  localparam int TSCHED_N_REQ = 4;
  localparam int TSCHED_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    FIRE  = 2'd2
  } tsched_state_e;

endpackage

// File: rtl/timer_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or above ptr_i,
// wrapping modulo N_REQ.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  ptr_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [ID_W-1:0]  grant_id_o,
  output logic             any_o
);

  logic [ID_W:0] idx;
  logic          found;

  // Scan requesters starting at ptr_i and pick the first one asserted.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves a value held over, which would infer a latch.
    grant_o    = '0;
    grant_id_o = '0;
    found      = 1'b0;
    idx        = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = {1'b0, ptr_i} + (ID_W+1)'(k);
      if (idx >= (ID_W+1)'(N_REQ)) begin
        idx = idx - (ID_W+1)'(N_REQ);
      end
      if (!found && req_i[idx[ID_W-1:0]]) begin
        found                       = 1'b1;
        grant_o[idx[ID_W-1:0]]      = 1'b1;
        grant_id_o                  = idx[ID_W-1:0];
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/timer_scheduler.sv
// One shared down-counter handing out one-shot timeouts to N_REQ
// requesters under round-robin arbitration.
module timer_scheduler
  import timer_pkg::*;
#(
  parameter int N_REQ = TSCHED_N_REQ,
  parameter int WIDTH = TSCHED_WIDTH,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_period,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ-1:0]       cancel,
  output logic [N_REQ-1:0]       expire,
  output logic                   busy,
  output logic [ID_W-1:0]        active_id,
  output logic [WIDTH-1:0]       remaining
);

  tsched_state_e    state_q;
  logic [WIDTH-1:0] count_q;
  logic [ID_W-1:0]  active_id_q;
  logic [ID_W-1:0]  rr_ptr_q;
  logic [ID_W-1:0]  rr_ptr_d;
  logic [N_REQ-1:0] expire_q;

  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0]  grant_id;
  logic             grant_any;
  logic [N_REQ-1:0] owner_onehot;
  logic [WIDTH-1:0] period_arr [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_period
    assign period_arr[i] = req_period[i*WIDTH +: WIDTH];
  end

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .req_i      (req_valid),
    .ptr_i      (rr_ptr_q),
    .grant_o    (grant),
    .grant_id_o (grant_id),
    .any_o      (grant_any)
  );

  // Pointer moves one past the winner so the winner goes to the back of the line.
  assign rr_ptr_d     = (grant_id == ID_W'(N_REQ-1)) ? '0 : grant_id + ID_W'(1);
  assign owner_onehot = N_REQ'(1) << active_id_q;

  assign req_ready = (state_q == IDLE) ? grant : '0;
  assign busy      = (state_q != IDLE);
  assign active_id = active_id_q;
  assign remaining = count_q;
  assign expire    = expire_q;

  // Scheduler FSM: accept in IDLE, count down in COUNT, pulse expire in FIRE.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register updates from pre-edge values, independent of statement order.
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      active_id_q <= '0;
      rr_ptr_q    <= '0;
      expire_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_any) begin
            count_q     <= period_arr[grant_id];
            active_id_q <= grant_id;
            rr_ptr_q    <= rr_ptr_d;
            state_q     <= COUNT;
          end
        end
        COUNT: begin
          // Owner cancel wins over reaching zero; other cancel bits are ignored.
          if (cancel[active_id_q]) begin
            state_q     <= IDLE;
            count_q     <= '0;
            active_id_q <= '0;
          end else if (count_q == '0) begin
            state_q  <= FIRE;
            expire_q <= owner_onehot;
          end else begin
            count_q <= count_q - WIDTH'(1);
          end
        end
        FIRE: begin
          expire_q    <= '0;
          state_q     <= IDLE;
          count_q     <= '0;
          active_id_q <= '0;
        end
        default: begin
          expire_q    <= '0;
          state_q     <= IDLE;
          count_q     <= '0;
          active_id_q <= '0;
        end
      endcase
    end
  end

endmodule
